envia_movimentos: RTL and testbench

Transmit-side counterpart of the move-reception path. On `iniciar`, walks the move memory from address 0 and converts each 3-bit move code to an ASCII letter. Each letter goes out on an 8N1 serial line; the sequence ends with a line feed, so the solver host and the debug terminal can read back the stored sequence. Contains its own control FSM, address counter and 8N1 transmitter; the move memory sits outside the block.

---
 rtl/envia_movimentos_if.sv | 40 ++++
 rtl/envia_movimentos.sv | 156 +++++++++++++++
 tb/tb_envia_movimentos.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/envia_movimentos_if.sv
`default_nettype none
// ============================================================================
//  Module      : envia_movimentos_if
//  Description : Control, memory-read and serial-line bundle for the move
//                transmitter. The slave side is the transmitter itself; the
//                master side is the host/memory environment around it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface envia_movimentos_if #(
  parameter int ADDR_W = 5
);
  logic              iniciar;
  logic [2:0]        movimento;
  logic [ADDR_W-1:0] endereco;
  logic              saida_serial;
  logic              ocupado;
  logic              pronto;
  logic [2:0]        db_estado;

  modport master (
    output iniciar,
    output movimento,
    input  endereco,
    input  saida_serial,
    input  ocupado,
    input  pronto,
    input  db_estado
  );

  modport slave (
    input  iniciar,
    input  movimento,
    output endereco,
    output saida_serial,
    output ocupado,
    output pronto,
    output db_estado
  );
endinterface
`default_nettype wire

// File: rtl/envia_movimentos.sv
`default_nettype none
// ============================================================================
//  Module      : envia_movimentos
//  Description : Walks the external move memory from address 0, converts each
//                3-bit move code to an ASCII letter and sends it on an 8N1
//                line, finishing the sequence with a line feed.
//                ADDR_W must match the ADDR_W of the connected interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module envia_movimentos #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 5
) (
  input  wire logic         clock,
  input  wire logic         reset,
  envia_movimentos_if.slave bus
);

  localparam int                CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [3:0]        BIT_STOP  = 4'd9;
  localparam logic [2:0]        MARCADOR  = 3'b111;
  localparam logic [7:0]        ASCII_LF  = 8'h0A;

  localparam logic [2:0] S_INICIAL   = 3'd0;
  localparam logic [2:0] S_PREPARA   = 3'd1;
  localparam logic [2:0] S_CARREGA   = 3'd2;
  localparam logic [2:0] S_TRANSMITE = 3'd3;
  localparam logic [2:0] S_PROXIMO   = 3'd4;
  localparam logic [2:0] S_FIM_LINHA = 3'd5;
  localparam logic [2:0] S_ENVIA_LF  = 3'd6;
  localparam logic [2:0] S_FINAL     = 3'd7;

  logic [2:0]        state_q,    state_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [7:0]        dado_q,     dado_d;
  logic [3:0]        bit_q,      bit_d;
  logic [CNT_W-1:0]  ciclo_q,    ciclo_d;
  logic              serial_q,   serial_d;

  // Move code to ASCII letter; the end marker never reaches this path.
  function automatic logic [7:0] decodifica(input logic [2:0] m);
    case (m)
      3'b000:  return 8'h55; // U
      3'b001:  return 8'h44; // D
      3'b010:  return 8'h4C; // L
      3'b011:  return 8'h52; // R
      3'b100:  return 8'h46; // F
      3'b101:  return 8'h42; // B
      default: return 8'h3F; // ?
    endcase
  endfunction

  // Line level for frame position b: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic nivel_quadro(input logic [3:0] b, input logic [7:0] d);
    if (b == 4'd0)
      return 1'b0;
    else if (b <= 4'd8)
      return d[b[2:0] - 3'd1];
    else
      return 1'b1;
  endfunction

  // State and datapath registers; the serial line is registered so it never glitches.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_INICIAL;
      endereco_q <= '0;
      dado_q     <= '0;
      bit_q      <= '0;
      ciclo_q    <= '0;
      serial_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      endereco_q <= endereco_d;
      dado_q     <= dado_d;
      bit_q      <= bit_d;
      ciclo_q    <= ciclo_d;
      serial_q   <= serial_d;
    end
  end

  // Next state, address walk, frame counters and next line level.
  always_comb begin
    state_d    = state_q;
    endereco_d = endereco_q;
    dado_d     = dado_q;
    bit_d      = bit_q;
    ciclo_d    = ciclo_q;
    case (state_q)
      S_INICIAL: begin
        endereco_d = '0;
        if (bus.iniciar) state_d = S_PREPARA;
      end
      S_PREPARA: state_d = S_CARREGA;
      S_CARREGA: begin
        bit_d   = '0;
        ciclo_d = '0;
        if (bus.movimento == MARCADOR) begin
          state_d = S_FIM_LINHA;
        end else begin
          dado_d  = decodifica(bus.movimento);
          state_d = S_TRANSMITE;
        end
      end
      S_TRANSMITE, S_ENVIA_LF: begin
        if (ciclo_q == CNT_LAST) begin
          ciclo_d = '0;
          if (bit_q == BIT_STOP) begin
            bit_d   = '0;
            state_d = (state_q == S_TRANSMITE) ? S_PROXIMO : S_FINAL;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          ciclo_d = ciclo_q + CNT_W'(1);
        end
      end
      S_PROXIMO: begin
        // Last address ends the sequence instead of wrapping.
        if (endereco_q == ADDR_LAST) begin
          state_d = S_FIM_LINHA;
        end else begin
          endereco_d = endereco_q + ADDR_W'(1);
          state_d    = S_PREPARA;
        end
      end
      S_FIM_LINHA: begin
        dado_d  = ASCII_LF;
        bit_d   = '0;
        ciclo_d = '0;
        state_d = S_ENVIA_LF;
      end
      S_FINAL: begin
        endereco_d = '0;
        state_d    = S_INICIAL;
      end
      default: state_d = S_INICIAL;
    endcase
    serial_d = ((state_d == S_TRANSMITE) || (state_d == S_ENVIA_LF))
               ? nivel_quadro(bit_d, dado_d) : 1'b1;
  end

  // Status outputs decoded from the current state.
  always_comb begin
    bus.ocupado   = (state_q != S_INICIAL);
    bus.pronto    = (state_q == S_FINAL);
    bus.db_estado = state_q;
  end

  assign bus.endereco     = endereco_q;
  assign bus.saida_serial = serial_q;

endmodule
`default_nettype wire

// File: tb/tb_envia_movimentos.sv
`default_nettype none
// ============================================================================
//  Module      : tb_envia_movimentos
//  Description : Directed self-checking bench for envia_movimentos with a
//                small synchronous-read move memory and a bit-sampling receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_envia_movimentos;

  localparam int CPB = 4;
  localparam int AW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  envia_movimentos_if #(.ADDR_W(AW)) bus ();

  envia_movimentos #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Move memory with one-cycle synchronous read
  logic [2:0] mem [0:3];
  always @(posedge clk) bus.movimento <= mem[bus.endereco];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;
  int pronto_cnt = 0;
  int occ_low = 0;
  int max_addr = 0;
  bit in_run = 1'b0;

  // Run-wide observations
  always @(negedge clk) begin
    if (bus.pronto === 1'b1) pronto_cnt++;
    if (in_run && bus.ocupado !== 1'b1) occ_low++;
    if (int'(bus.endereco) > max_addr) max_addr = int'(bus.endereco);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_fall(input int limit, output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < limit; i++) begin
      if (bus.saida_serial === 1'b0) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic rx_frame(input string tag, input logic [7:0] exp, input bit poke, output int t);
    bit ok;
    logic [7:0] b;
    b = '0;
    wait_fall(200, ok, t);
    check({tag, "_start_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      @(negedge clk);
      if (poke) bus.iniciar = 1'b1;
      @(negedge clk);
      if (poke) bus.iniciar = 1'b0;
      check({tag, "_startbit"}, 32'(bus.saida_serial), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = bus.saida_serial;
      end
      check({tag, "_byte"}, 32'(b), 32'(exp));
      repeat (CPB) @(negedge clk);
      check({tag, "_stopbit"}, 32'(bus.saida_serial), 32'd1);
    end
  endtask

  task automatic wait_pronto(input string tag, output int t);
    bit ok;
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.pronto === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_pronto_seen"}, 32'(ok), 32'd1);
    in_run = 1'b0;
  endtask

  task automatic start_run(input string tag, input bit lat);
    @(negedge clk);
    bus.iniciar = 1'b1;
    pronto_cnt  = 0;
    occ_low     = 0;
    max_addr    = 0;
    @(negedge clk);
    bus.iniciar = 1'b0;
    in_run      = 1'b1;
    if (lat) begin
      check({tag, "_st_prepara"}, 32'(bus.db_estado), 32'd1);
      @(negedge clk);
      check({tag, "_st_carrega"}, 32'(bus.db_estado), 32'd2);
      check({tag, "_idle_e1"}, 32'(bus.saida_serial), 32'd1);
      @(negedge clk);
      check({tag, "_st_transmite"}, 32'(bus.db_estado), 32'd3);
      check({tag, "_start_e2"}, 32'(bus.saida_serial), 32'd0);
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_end_addr"}, 32'(bus.endereco), 32'd0);
    check({tag, "_end_state"}, 32'(bus.db_estado), 32'd0);
    check({tag, "_end_busy"}, 32'(bus.ocupado), 32'd0);
    repeat (5) @(negedge clk);
    check({tag, "_pronto_count"}, 32'(pronto_cnt), 32'd1);
  endtask

  initial begin
    int t1, t2, t3, t4, t5, tp;
    bit ok;
    bus.iniciar = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 3'b111;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_state", 32'(bus.db_estado), 32'd0);
    check("rst_addr", 32'(bus.endereco), 32'd0);
    check("rst_serial", 32'(bus.saida_serial), 32'd1);
    check("rst_busy", 32'(bus.ocupado), 32'd0);
    check("rst_pronto", 32'(bus.pronto), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // U, R, marker: start latency, frame spacing, pronto timing
    mem[0] = 3'b000; mem[1] = 3'b011; mem[2] = 3'b111; mem[3] = 3'b000;
    start_run("t1", 1'b1);
    rx_frame("t1_U", 8'h55, 1'b0, t1);
    rx_frame("t1_R", 8'h52, 1'b0, t2);
    rx_frame("t1_LF", 8'h0A, 1'b0, t3);
    wait_pronto("t1", tp);
    check("t1_gap_UR", 32'(t2 - t1), 32'd43);
    check("t1_gap_RLF", 32'(t3 - t2), 32'd44);
    check("t1_lf_to_pronto", 32'(tp - t3), 32'd40);
    check_idle("t1");
    check("t1_max_addr", 32'(max_addr), 32'd2);

    // Marker at address 0: LF only
    mem[0] = 3'b111;
    start_run("t3", 1'b0);
    rx_frame("t3_LF", 8'h0A, 1'b0, t1);
    wait_pronto("t3", tp);
    check("t3_lf_to_pronto", 32'(tp - t1), 32'd40);
    check("t3_busy_gaps", 32'(occ_low), 32'd0);
    check_idle("t3");

    // Full memory, no marker: four letters then LF, no wrap
    mem[0] = 3'b100; mem[1] = 3'b101; mem[2] = 3'b010; mem[3] = 3'b110;
    start_run("t4", 1'b0);
    rx_frame("t4_F", 8'h46, 1'b0, t1);
    rx_frame("t4_B", 8'h42, 1'b0, t2);
    rx_frame("t4_L", 8'h4C, 1'b0, t3);
    rx_frame("t4_Q", 8'h3F, 1'b0, t4);
    rx_frame("t4_LF", 8'h0A, 1'b0, t5);
    wait_pronto("t4", tp);
    check("t4_gap_QLF", 32'(t5 - t4), 32'd42);
    check("t4_max_addr", 32'(max_addr), 32'd3);
    check_idle("t4");

    // iniciar re-pulsed during the second frame is ignored
    mem[0] = 3'b000; mem[1] = 3'b001; mem[2] = 3'b111;
    start_run("t5", 1'b0);
    rx_frame("t5_U", 8'h55, 1'b0, t1);
    rx_frame("t5_D", 8'h44, 1'b1, t2);
    rx_frame("t5_LF", 8'h0A, 1'b0, t3);
    wait_pronto("t5", tp);
    check_idle("t5");
    wait_fall(100, ok, t1);
    check("t5_no_restart", 32'(ok), 32'd0);
    check("t5_pronto_total", 32'(pronto_cnt), 32'd1);

    // Reset during a data bit of the second frame, then a clean rerun
    mem[0] = 3'b011; mem[1] = 3'b000; mem[2] = 3'b111;
    start_run("t6", 1'b0);
    rx_frame("t6_R", 8'h52, 1'b0, t1);
    wait_fall(100, ok, t2);
    check("t6_f2_seen", 32'(ok), 32'd1);
    repeat (10) @(negedge clk);
    check("t6_addr_before", 32'(bus.endereco), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    in_run = 1'b0;
    check("t6_rst_serial", 32'(bus.saida_serial), 32'd1);
    check("t6_rst_state", 32'(bus.db_estado), 32'd0);
    check("t6_rst_addr", 32'(bus.endereco), 32'd0);
    check("t6_rst_busy", 32'(bus.ocupado), 32'd0);
    wait_fall(60, ok, t3);
    check("t6_no_resume", 32'(ok), 32'd0);
    start_run("t6b", 1'b1);
    rx_frame("t6b_R", 8'h52, 1'b0, t1);
    rx_frame("t6b_U", 8'h55, 1'b0, t2);
    rx_frame("t6b_LF", 8'h0A, 1'b0, t3);
    wait_pronto("t6b", tp);
    check_idle("t6b");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
